// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo -- receive-side byte FIFO sitting behind a UART receiver.
//
// A rising edge on rxd_readyH writes RDR into the FIFO (a level held high
// writes once). The consumer pops bytes with rd_en; the popped byte appears on
// rd_data one clock later, qualified by a one-cycle rd_valid pulse. A byte that
// arrives while the FIFO is full (with no simultaneous pop) is dropped and
// raises the sticky overrun flag, cleared by ovr_clr.
//
// Ports:
//   sysclk      in   clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   RDR         in   [7:0] received byte, valid while rxd_readyH is high
//   rxd_readyH  in   byte-ready flag from the receiver
//   rd_en       in   consumer read request
//   ovr_clr     in   clear sticky overrun
//   rd_data     out  [7:0] registered read data
//   rd_valid    out  one-cycle pulse marking rd_data valid
//   empty       out  count == 0
//   full        out  count == DEPTH
//   count       out  [$clog2(DEPTH):0] number of stored bytes
//   overrun     out  sticky dropped-byte flag
//   rx_irq      out  count >= THRESH or overrun
module uart_rx_fifo #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned THRESH = 8
) (
    input  logic                     sysclk,
    input  logic                     rst_n,
    input  logic [7:0]               RDR,
    input  logic                     rxd_readyH,
    input  logic                     rd_en,
    input  logic                     ovr_clr,
    output logic [7:0]               rd_data,
    output logic                     rd_valid,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overrun,
    output logic                     rx_irq
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [7:0]    mem [DEPTH];

    logic          rdy_q;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovr_q, ovr_d;
    logic [7:0]    rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d;

    logic          wr_stb;
    logic          rd_acc;
    logic          wr_acc;
    logic          ovr_evt;
    logic          empty_w;
    logic          full_w;

    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == CW'(DEPTH));

    assign wr_stb  = rxd_readyH & ~rdy_q;
    assign rd_acc  = rd_en & ~empty_w;
    // A pop in the same cycle frees the slot, so a write into a full FIFO is
    // still accepted then; when full both pointers coincide and the read
    // below sees the old entry because the memory updates non-blocking.
    assign wr_acc  = wr_stb & (~full_w | rd_acc);
    assign ovr_evt = wr_stb & full_w & ~rd_acc;

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        ovr_d      = ovr_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;

        if (wr_acc) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (rd_acc) begin
            rptr_d     = rptr_q + AW'(1);
            rd_data_d  = mem[rptr_q];
            rd_valid_d = 1'b1;
        end
        if (wr_acc && !rd_acc) begin
            count_d = count_q + CW'(1);
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - CW'(1);
        end
        // Set wins over clear.
        if (ovr_evt) begin
            ovr_d = 1'b1;
        end else if (ovr_clr) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q      <= 1'b0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            ovr_q      <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rdy_q      <= rxd_readyH;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            ovr_q      <= ovr_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Storage is not reset; the pointers and count define what is valid.
    always_ff @(posedge sysclk) begin
        if (wr_acc) begin
            mem[wptr_q] <= RDR;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign empty    = empty_w;
    assign full     = full_w;
    assign count    = count_q;
    assign overrun  = ovr_q;
    assign rx_irq   = (count_q >= CW'(THRESH)) | ovr_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed testbench for uart_rx_fifo (DEPTH=16, THRESH=8).
module tb_uart_rx_fifo;

    logic       sysclk;
    logic       rst_n;
    logic [7:0] RDR;
    logic       rxd_readyH;
    logic       rd_en;
    logic       ovr_clr;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       overrun;
    logic       rx_irq;

    int errors = 0;
    int checks = 0;

    uart_rx_fifo #(.DEPTH(16), .THRESH(8)) dut (
        .sysclk     (sysclk),
        .rst_n      (rst_n),
        .RDR        (RDR),
        .rxd_readyH (rxd_readyH),
        .rd_en      (rd_en),
        .ovr_clr    (ovr_clr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .empty      (empty),
        .full       (full),
        .count      (count),
        .overrun    (overrun),
        .rx_irq     (rx_irq)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    // Single-cycle rxd_readyH pulse followed by one low cycle.
    task automatic wr(input logic [7:0] b);
        RDR = b;
        rxd_readyH = 1'b1;
        tick();
        rxd_readyH = 1'b0;
        tick();
    endtask

    // One-cycle rd_en; on return rd_data/rd_valid reflect that read.
    task automatic rd_pulse();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; RDR = '0; rxd_readyH = 1'b0; rd_en = 1'b0; ovr_clr = 1'b0;
        #12;
        if ({empty, full, count, overrun, rx_irq, rd_valid, rd_data} !== {1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL reset_state: got e=%b f=%b c=%0d o=%b i=%b v=%b d=%h want e=1 f=0 c=0 o=0 i=0 v=0 d=00",
                     empty, full, count, overrun, rx_irq, rd_valid, rd_data);
        end
        checks++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [7:0] exp_b [3];
        exp_b[0] = 8'h41; exp_b[1] = 8'h42; exp_b[2] = 8'h43;
        for (int i = 0; i < 3; i++) wr(exp_b[i]);
        if (count !== 5'd3) begin
            errors++; $display("FAIL basic_count: got %0d want 3", count);
        end
        checks++;
        for (int i = 0; i < 3; i++) begin
            rd_pulse();
            if (rd_valid !== 1'b1 || rd_data !== exp_b[i]) begin
                errors++; $display("FAIL basic_read%0d: got v=%b d=%h want v=1 d=%h", i, rd_valid, rd_data, exp_b[i]);
            end
            checks++;
            tick();
            if (rd_valid !== 1'b0) begin
                errors++; $display("FAIL basic_pulse%0d: rd_valid got %b want 0", i, rd_valid);
            end
            checks++;
        end
        if (empty !== 1'b1 || count !== 5'd0) begin
            errors++; $display("FAIL basic_empty: got e=%b c=%0d want e=1 c=0", empty, count);
        end
        checks++;
    endtask

    task automatic test_overrun();
        for (int i = 0; i < 16; i++) wr(8'h10 + 8'(i));
        if (full !== 1'b1 || count !== 5'd16 || overrun !== 1'b0 || rx_irq !== 1'b1) begin
            errors++; $display("FAIL ovr_fill: got f=%b c=%0d o=%b i=%b want f=1 c=16 o=0 i=1", full, count, overrun, rx_irq);
        end
        checks++;
        wr(8'hFF);
        if (full !== 1'b1 || count !== 5'd16 || overrun !== 1'b1 || rx_irq !== 1'b1) begin
            errors++; $display("FAIL ovr_drop: got f=%b c=%0d o=%b i=%b want f=1 c=16 o=1 i=1", full, count, overrun, rx_irq);
        end
        checks++;
        for (int i = 0; i < 16; i++) begin
            rd_pulse();
            if (rd_valid !== 1'b1 || rd_data !== 8'h10 + 8'(i)) begin
                errors++; $display("FAIL ovr_read%0d: got v=%b d=%h want v=1 d=%h", i, rd_valid, rd_data, 8'h10 + 8'(i));
            end
            checks++;
        end
        tick();
        if (empty !== 1'b1 || overrun !== 1'b1 || rx_irq !== 1'b1) begin
            errors++; $display("FAIL ovr_sticky: got e=%b o=%b i=%b want e=1 o=1 i=1", empty, overrun, rx_irq);
        end
        checks++;
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        if (overrun !== 1'b0 || rx_irq !== 1'b0) begin
            errors++; $display("FAIL ovr_clear: got o=%b i=%b want o=0 i=0", overrun, rx_irq);
        end
        checks++;
    endtask

    task automatic test_full_simul();
        for (int i = 0; i < 16; i++) wr(8'h20 + 8'(i));
        RDR = 8'h55;
        rxd_readyH = 1'b1;
        rd_en = 1'b1;
        tick();
        rxd_readyH = 1'b0;
        rd_en = 1'b0;
        if (count !== 5'd16 || overrun !== 1'b0 || rd_valid !== 1'b1 || rd_data !== 8'h20) begin
            errors++; $display("FAIL simul_full: got c=%0d o=%b v=%b d=%h want c=16 o=0 v=1 d=20", count, overrun, rd_valid, rd_data);
        end
        checks++;
        tick();
        for (int i = 1; i < 16; i++) begin
            rd_pulse();
            if (rd_data !== 8'h20 + 8'(i)) begin
                errors++; $display("FAIL simul_read%0d: got %h want %h", i, rd_data, 8'h20 + 8'(i));
            end
            checks++;
        end
        rd_pulse();
        if (rd_valid !== 1'b1 || rd_data !== 8'h55 || empty !== 1'b1) begin
            errors++; $display("FAIL simul_last: got v=%b d=%h e=%b want v=1 d=55 e=1", rd_valid, rd_data, empty);
        end
        checks++;
        tick();
    endtask

    task automatic test_held_ready();
        RDR = 8'h3C;
        rxd_readyH = 1'b1;
        repeat (5) tick();
        rxd_readyH = 1'b0;
        tick();
        if (count !== 5'd1) begin
            errors++; $display("FAIL held_count: got %0d want 1", count);
        end
        checks++;
        rd_pulse();
        if (rd_data !== 8'h3C || empty !== 1'b1) begin
            errors++; $display("FAIL held_read: got d=%h e=%b want d=3c e=1", rd_data, empty);
        end
        checks++;
        tick();
    endtask

    task automatic test_empty_read_irq();
        rd_pulse();
        if (rd_valid !== 1'b0 || count !== 5'd0 || rd_data !== 8'h3C) begin
            errors++; $display("FAIL empty_read: got v=%b c=%0d d=%h want v=0 c=0 d=3c", rd_valid, count, rd_data);
        end
        checks++;
        for (int i = 0; i < 8; i++) begin
            logic exp_irq;
            wr(8'h60 + 8'(i));
            exp_irq = ((i + 1) >= 8);
            if (rx_irq !== exp_irq || count !== 5'(i + 1)) begin
                errors++; $display("FAIL irq_level%0d: got i=%b c=%0d want i=%b c=%0d", i, rx_irq, count, exp_irq, i + 1);
            end
            checks++;
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 8; i++) wr(8'h70 + 8'(i));
        wr(8'hFF);
        for (int i = 0; i < 11; i++) rd_pulse();
        tick();
        if (count !== 5'd5 || overrun !== 1'b1 || rd_data !== 8'h72) begin
            errors++; $display("FAIL areset_pre: got c=%0d o=%b d=%h want c=5 o=1 d=72", count, overrun, rd_data);
        end
        checks++;
        @(posedge sysclk);
        #3;
        rst_n = 1'b0;
        #1;
        if ({empty, full, count, overrun, rx_irq, rd_valid, rd_data} !== {1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL areset_state: got e=%b f=%b c=%0d o=%b i=%b v=%b d=%h want e=1 f=0 c=0 o=0 i=0 v=0 d=00",
                     empty, full, count, overrun, rx_irq, rd_valid, rd_data);
        end
        checks++;
        @(negedge sysclk);
        rst_n = 1'b1;
        RDR = 8'h77;
        rxd_readyH = 1'b1;
        tick();
        rxd_readyH = 1'b0;
        if (count !== 5'd1 || empty !== 1'b0) begin
            errors++; $display("FAIL post_reset_write: got c=%0d e=%b want c=1 e=0", count, empty);
        end
        checks++;
        tick();
        rd_pulse();
        if (rd_valid !== 1'b1 || rd_data !== 8'h77 || empty !== 1'b1) begin
            errors++; $display("FAIL post_reset_read: got v=%b d=%h e=%b want v=1 d=77 e=1", rd_valid, rd_data, empty);
        end
        checks++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_full_simul();
        test_held_ready();
        test_empty_read_irq();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
